// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encodings, FSM states and helpers.
package hilo_muldiv_unit_pkg;

    localparam int MULDIV_OP_W = 4;

    typedef enum logic [MULDIV_OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } muldiv_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE,
        S_ACC
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_iter.sv
// Unsigned restoring divider core retiring DIV_STEP quotient bits per cycle.
module hilo_muldiv_unit_div_iter #(
    parameter int XLEN     = 32,
    parameter int DIV_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int ITERS = XLEN / DIV_STEP;
    localparam int CNT_W = $clog2(ITERS + 1);

    logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
    logic [XLEN-1:0]  rem_d, quo_d;
    logic [XLEN:0]    trial;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: every always_comb output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        trial = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            trial = {rem_d, quo_d[XLEN-1]};
            quo_d = {quo_d[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial    = trial - {1'b0, dvs_q};
                quo_d[0] = 1'b1;
            end
            rem_d = trial[XLEN-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= CNT_W'(ITERS);
        end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Outputs are the post-step values, so they are final in the same cycle done_o is high.
    assign done_o      = (cnt_q == CNT_W'(1));
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the EXE stage.
// Define HILO_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_LAT  = 3,
    parameter int DIV_STEP = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MULDIV_OP_W-1:0] op,
    input  logic [XLEN-1:0]        src1,
    input  logic [XLEN-1:0]        src2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        result,
    input  logic                   wr_disable,
    input  logic                   flush,
    output logic                   busy
);

`ifdef HILO_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);

    muldiv_state_t       state_q, state_d;
    muldiv_op_t          op_in, op_q;
    logic [XLEN-1:0]     hi_q, lo_q, src1_q;
    logic [2*XLEN-1:0]   res_q, res_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign1_q, sign2_q, div_zero_q;

    logic                accept, commit, div_start, div_done;
    logic                neg1, neg2, is_mul_in, is_madd_in, is_div_in, madd_q, msub_q;
    logic                wr_hi, wr_lo;
    logic [XLEN-1:0]     mag1, mag2, quotient, remainder, quo_fix, rem_fix;
    logic [2*XLEN-1:0]   prod_mag, prod_in;

    assign op_in      = muldiv_op_t'(op);
    assign accept     = in_valid && (state_q == S_IDLE) && (op_in != OP_NOP) && !flush;
    assign neg1       = op_is_signed(op_in) && src1[XLEN-1];
    assign neg2       = op_is_signed(op_in) && src2[XLEN-1];
    assign mag1       = neg1 ? -src1 : src1;
    assign mag2       = neg2 ? -src2 : src2;
    assign prod_mag   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    assign prod_in    = (neg1 ^ neg2) ? -prod_mag : prod_mag;
    assign is_madd_in = MADD_EN && (op_in inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
    assign is_mul_in  = (op_in inside {OP_MULT, OP_MULTU}) || is_madd_in;
    assign is_div_in  = op_in inside {OP_DIV, OP_DIVU};
    assign madd_q     = MADD_EN && (op_q inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
    assign msub_q     = op_q inside {OP_MSUB, OP_MSUBU};

    // Quotient takes the XOR of operand signs; remainder follows the dividend.
    assign quo_fix = (sign1_q ^ sign2_q) ? -quotient : quotient;
    assign rem_fix = sign1_q ? -remainder : remainder;

    hilo_muldiv_unit_div_iter #(.XLEN(XLEN), .DIV_STEP(DIV_STEP)) u_div_iter (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_start),
        .dividend_i  (mag1),
        .divisor_i   (mag2),
        .done_o      (div_done),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        div_start = 1'b0;
        unique case (state_q)
            S_IDLE: if (accept) begin
                if (is_mul_in) begin
                    res_d = prod_in;
                    cnt_d = CNT_W'(MUL_LAT - 1);
                    if (MUL_LAT > 1)     state_d = S_MUL;
                    else if (is_madd_in) state_d = S_ACC;
                    else                 state_d = S_DONE;
                end else if (is_div_in) begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = madd_q ? S_ACC : S_DONE;
            end
            S_ACC: begin
                res_d   = msub_q ? ({hi_q, lo_q} - res_q) : ({hi_q, lo_q} + res_q);
                state_d = S_DONE;
            end
            S_DIV: if (div_done) begin
                res_d   = div_zero_q ? {src1_q, {XLEN{1'b1}}} : {rem_fix, quo_fix};
                state_d = S_DONE;
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    assign commit = (state_q == S_DONE) && out_ready && !wr_disable && !flush;
    assign wr_hi  = (op_q inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI}) || madd_q;
    assign wr_lo  = (op_q inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTLO}) || madd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            hi_q       <= '0;
            lo_q       <= '0;
            src1_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q       <= op_in;
                src1_q     <= src1;
                sign1_q    <= neg1;
                sign2_q    <= neg2;
                div_zero_q <= (src2 == '0);
            end
            if (commit && wr_hi) hi_q <= (op_q == OP_MTHI) ? src1_q : res_q[2*XLEN-1:XLEN];
            if (commit && wr_lo) lo_q <= (op_q == OP_MTLO) ? src1_q : res_q[XLEN-1:0];
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);

    always_comb begin
        result = '0;
        if (state_q == S_DONE) begin
            if (op_q == OP_MFHI)      result = hi_q;
            else if (op_q == OP_MFLO) result = lo_q;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit (XLEN=32, MUL_LAT=3, DIV_STEP=1).
module tb_hilo_muldiv_unit;

    localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;
    localparam logic [3:0] MADDU = 4'd10, MSUBU = 4'd12;

`ifdef HILO_MADD_EN
    localparam int MADD_LAT = 4;
`else
    localparam int MADD_LAT = 1;
`endif

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, wr_disable, flush;
    logic [3:0]  op;
    logic [31:0] src1, src2, result;
    logic        in_ready, out_valid, busy;

    exp_t sb_q[$];
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, acc_cyc = 0, first_cyc = 0;
    bit   prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hilo_muldiv_unit #(.XLEN(32), .MUL_LAT(3), .DIV_STEP(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .src1       (src1),
        .src2       (src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .wr_disable (wr_disable),
        .flush      (flush),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready && op != NOP && !flush) acc_cyc = cyc;
            if (out_valid) begin
                if (!prev_valid) first_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("unexpected out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check({sb_q[0].tag, " result"}, result, sb_q[0].res);
                    check({sb_q[0].tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
                    if (!prev_valid)
                        check({sb_q[0].tag, " latency"}, 32'(first_cyc - acc_cyc), 32'(sb_q[0].lat));
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic issue(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int lat,
                         input logic wd, input int hold);
        int n = 0;
        sb_q.push_back('{tag, exp_res, lat});
        in_valid = 1'b1; op = o; src1 = a; src2 = b; wr_disable = wd;
        @(posedge clk); #1;
        in_valid = 1'b0; op = NOP;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            check({tag, " timeout"}, {31'd0, out_valid}, 32'd1);
            sb_q.delete();
        end else begin
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        wr_disable = 1'b0;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue({tag, " MFHI"}, MFHI, 32'd0, 32'd0, exp_hi, 1, 1'b0, 0);
        issue({tag, " MFLO"}, MFLO, 32'd0, 32'd0, exp_lo, 1, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = NOP; src1 = '0; src2 = '0;
        out_ready = 1'b0; wr_disable = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset result", result, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);

        issue("MULT -2*3", MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 3, 1'b0, 0);
        read_hilo("MULT", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue("MULTU max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 3, 1'b0, 0);
        read_hilo("MULTU", 32'hFFFF_FFFE, 32'h0000_0001);

        issue("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd0, 33, 1'b0, 0);
        read_hilo("DIVU", 32'd2, 32'd14);
        issue("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 33, 1'b0, 0);
        read_hilo("DIV neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue("DIV by zero", DIV, 32'h0000_1234, 32'd0, 32'd0, 33, 1'b0, 0);
        read_hilo("DIV0", 32'h0000_1234, 32'hFFFF_FFFF);
        issue("DIV min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0, 0);
        read_hilo("DIV ovf", 32'd0, 32'h8000_0000);

        // Cancelled divide: no scoreboard entry, so any out_valid is flagged.
        in_valid = 1'b1; op = DIVU; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0; op = NOP;
        repeat (9) begin @(posedge clk); #1; end
        check("mid-divide busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        check("flush busy", {31'd0, busy}, 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        read_hilo("after flush", 32'd0, 32'h8000_0000);

        in_valid = 1'b1; op = MTHI; src1 = 32'h0000_0999; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = NOP; flush = 1'b0;
        check("flush vs accept in_ready", {31'd0, in_ready}, 32'd1);
        check("flush vs accept out_valid", {31'd0, out_valid}, 32'd0);
        read_hilo("flush vs accept", 32'd0, 32'h8000_0000);

        issue("MTLO wr_disable hold", MTLO, 32'h0000_0055, 32'd0, 32'd0, 1, 1'b1, 4);
        read_hilo("wr_disable", 32'd0, 32'h8000_0000);
        issue("MTHI", MTHI, 32'h0000_ABCD, 32'd0, 32'd0, 1, 1'b0, 0);
        read_hilo("MTHI", 32'h0000_ABCD, 32'h8000_0000);
        issue("DIV 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd0, 33, 1'b0, 2);
        read_hilo("DIV rem sign", 32'd1, 32'hFFFF_FFFD);

        issue("MTHI 0", MTHI, 32'd0, 32'd0, 32'd0, 1, 1'b0, 0);
        issue("MTLO ones", MTLO, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 1'b0, 0);
        issue("MADDU 1*1", MADDU, 32'd1, 32'd1, 32'd0, MADD_LAT, 1'b0, 0);
`ifdef HILO_MADD_EN
        read_hilo("MADDU", 32'd1, 32'd0);
`else
        read_hilo("MADDU", 32'd0, 32'hFFFF_FFFF);
`endif
        issue("MSUBU 2*3", MSUBU, 32'd2, 32'd3, 32'd0, MADD_LAT, 1'b0, 0);
`ifdef HILO_MADD_EN
        read_hilo("MSUBU", 32'd0, 32'hFFFF_FFFA);
`else
        read_hilo("MSUBU", 32'd0, 32'hFFFF_FFFF);
`endif

        repeat (3) @(posedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
